// File: rtl/train_pkg.sv
// Shared definitions for the training-loop controller.
// Holds the default parameter widths and the controller state encoding.
package train_pkg;

  localparam int unsigned DEF_LAYER_ADDR_WIDTH = 2;
  localparam int unsigned DEF_LAYER_MAX        = 3;
  localparam int unsigned DEF_SAMPLE_ADDR_SIZE = 10;
  localparam int unsigned DEF_EPOCH_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FP     = 3'd2,
    ST_BP     = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/training_sequencer.sv
// Training-loop controller: walks every epoch, every sample and every layer,
// issuing forward-pass launches (with activation-stack writes) followed by
// backprop launches from the top layer down to layer 1.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      run launch (IDLE only) / run cancel (beats all but rst)
//   cfg_layers/samples/epochs   run configuration, latched at start
//   sample_addr, current_layer, epoch   registered loop counters
//   fp_start/fp_valid, bp_start/bp_valid  launch pulses / completion inputs
//   stack_wr_en, stack_wr_addr          combinational stack write port
//   sample_done, busy, done             registered status outputs
module training_sequencer
  import train_pkg::*;
#(
  parameter int unsigned LAYER_ADDR_WIDTH = DEF_LAYER_ADDR_WIDTH,
  parameter int unsigned LAYER_MAX        = DEF_LAYER_MAX,
  parameter int unsigned SAMPLE_ADDR_SIZE = DEF_SAMPLE_ADDR_SIZE,
  parameter int unsigned EPOCH_WIDTH      = DEF_EPOCH_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LAYER_ADDR_WIDTH-1:0] cfg_layers,
  input  logic [SAMPLE_ADDR_SIZE-1:0] cfg_samples,
  input  logic [EPOCH_WIDTH-1:0]      cfg_epochs,
  output logic [SAMPLE_ADDR_SIZE-1:0] sample_addr,
  output logic [LAYER_ADDR_WIDTH-1:0] current_layer,
  output logic [EPOCH_WIDTH-1:0]      epoch,
  output logic                        fp_start,
  input  logic                        fp_valid,
  output logic                        bp_start,
  input  logic                        bp_valid,
  output logic                        stack_wr_en,
  output logic [LAYER_ADDR_WIDTH-1:0] stack_wr_addr,
  output logic                        sample_done,
  output logic                        busy,
  output logic                        done
);

  state_t                      r_state;
  logic [LAYER_ADDR_WIDTH-1:0] r_layers;
  logic [SAMPLE_ADDR_SIZE-1:0] r_samples;
  logic [EPOCH_WIDTH-1:0]      r_epochs;
  logic [SAMPLE_ADDR_SIZE-1:0] r_sample_addr;
  logic [LAYER_ADDR_WIDTH-1:0] r_layer;
  logic [EPOCH_WIDTH-1:0]      r_epoch;
  logic                        r_fp_start;
  logic                        r_bp_start;
  logic                        r_sample_done;
  logic                        r_busy;
  logic                        r_done;
  logic [LAYER_ADDR_WIDTH-1:0] w_layers_clamped;

  always_comb begin
    w_layers_clamped = cfg_layers;
    if (32'(cfg_layers) > LAYER_MAX)
      w_layers_clamped = LAYER_ADDR_WIDTH'(LAYER_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state       <= ST_IDLE;
      r_layers      <= '0;
      r_samples     <= '0;
      r_epochs      <= '0;
      r_sample_addr <= '0;
      r_layer       <= '0;
      r_epoch       <= '0;
      r_fp_start    <= 1'b0;
      r_bp_start    <= 1'b0;
      r_sample_done <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_fp_start    <= 1'b0;
      r_bp_start    <= 1'b0;
      r_sample_done <= 1'b0;
      r_done        <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_layers  <= w_layers_clamped;
            r_samples <= cfg_samples;
            r_epochs  <= cfg_epochs;
            r_busy    <= 1'b1;
            if (w_layers_clamped == '0 || cfg_samples == '0 || cfg_epochs == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_sample_addr <= '0;
              r_epoch       <= '0;
              r_layer       <= '0;
              r_state       <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_state    <= ST_FP;
          r_fp_start <= 1'b1;
        end
        ST_FP: begin
          if (fp_valid) begin
            if (r_layer == r_layers - LAYER_ADDR_WIDTH'(1)) begin
              r_layer    <= r_layers;
              r_state    <= ST_BP;
              r_bp_start <= 1'b1;
            end else begin
              r_layer    <= r_layer + LAYER_ADDR_WIDTH'(1);
              r_fp_start <= 1'b1;
            end
          end
        end
        ST_BP: begin
          if (bp_valid) begin
            if (r_layer > LAYER_ADDR_WIDTH'(1)) begin
              r_layer    <= r_layer - LAYER_ADDR_WIDTH'(1);
              r_bp_start <= 1'b1;
            end else begin
              r_sample_done <= 1'b1;
              if (r_sample_addr < r_samples - SAMPLE_ADDR_SIZE'(1)) begin
                r_sample_addr <= r_sample_addr + SAMPLE_ADDR_SIZE'(1);
                r_layer       <= '0;
                r_state       <= ST_LOAD;
              end else if (r_epoch < r_epochs - EPOCH_WIDTH'(1)) begin
                r_epoch       <= r_epoch + EPOCH_WIDTH'(1);
                r_sample_addr <= '0;
                r_layer       <= '0;
                r_state       <= ST_LOAD;
              end else begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_FINISH: begin
          // A completed run already raised done on entry; an empty run
          // (zero layers/samples/epochs) raises it on the way out instead.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= ~r_done;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stack_wr_en   = (r_state == ST_FP) && fp_valid && !abort && !rst;
  assign stack_wr_addr = r_layer + LAYER_ADDR_WIDTH'(1);

  assign sample_addr   = r_sample_addr;
  assign current_layer = r_layer;
  assign epoch         = r_epoch;
  assign fp_start      = r_fp_start;
  assign bp_start      = r_bp_start;
  assign sample_done   = r_sample_done;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: two instances (LAYER_MAX 3 and 2) share the
// run controls; each has its own valid responder. A run is modelled as a flat
// list of operations indexed by a single counter.
module tb_training_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_layers = '0;
  logic [9:0] cfg_samples = '0;
  logic [7:0] cfg_epochs = '0;

  logic [9:0] sa [2];
  logic [1:0] cl [2];
  logic [7:0] ep [2];
  logic [1:0] wad [2];
  logic       fps [2], bps [2], fpv [2], bpv [2], wen [2], sd [2], bz [2], dn [2];

  always #5 clk = ~clk;

  training_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(3), .SAMPLE_ADDR_SIZE(10), .EPOCH_WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_layers(cfg_layers), .cfg_samples(cfg_samples), .cfg_epochs(cfg_epochs),
    .sample_addr(sa[0]), .current_layer(cl[0]), .epoch(ep[0]),
    .fp_start(fps[0]), .fp_valid(fpv[0]), .bp_start(bps[0]), .bp_valid(bpv[0]),
    .stack_wr_en(wen[0]), .stack_wr_addr(wad[0]),
    .sample_done(sd[0]), .busy(bz[0]), .done(dn[0]));

  training_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(2), .SAMPLE_ADDR_SIZE(10), .EPOCH_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_layers(cfg_layers), .cfg_samples(cfg_samples), .cfg_epochs(cfg_epochs),
    .sample_addr(sa[1]), .current_layer(cl[1]), .epoch(ep[1]),
    .fp_start(fps[1]), .fp_valid(fpv[1]), .bp_start(bps[1]), .bp_valid(bpv[1]),
    .stack_wr_en(wen[1]), .stack_wr_addr(wad[1]),
    .sample_done(sd[1]), .busy(bz[1]), .done(dn[1]));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d (cycle %0d)", name, u, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 BRAM prefetch gap, 2 waiting on an op, 3 empty-run finish, 4 finish
  int LMAX [2] = '{3, 2};
  int m_mode [2] = '{0, 0};
  int m_L [2], m_N [2], m_E [2], m_op [2];
  int h_s [2] = '{0, 0};
  int h_l [2] = '{0, 0};
  int h_e [2] = '{0, 0};
  bit e_fp [2], e_bp [2], e_sd [2], e_busy [2], e_done [2];

  // op index -> (layer, sample, epoch, is-forward); each sample is L forward
  // ops on layers 0..L-1 followed by L backward ops on layers L..1
  function automatic void dec(input int L, input int N, input int opi,
                              output int lay, output int smp, output int epn, output bit isfp);
    int per, k;
    per  = 2 * L;
    k    = opi % per;
    smp  = (opi / per) % N;
    epn  = opi / (per * N);
    isfp = (k < L);
    lay  = isfp ? k : per - k;
  endfunction

  task automatic model_step(input int u);
    int lay, smp, epn, L;
    bit isfp, nfp;
    e_fp[u] = 0; e_bp[u] = 0; e_sd[u] = 0; e_done[u] = 0;
    if (rst || abort) begin
      m_mode[u] = 0; h_s[u] = 0; h_l[u] = 0; h_e[u] = 0; e_busy[u] = 0;
    end else begin
      case (m_mode[u])
        0: if (start) begin
          L = int'(cfg_layers);
          if (L > LMAX[u]) L = LMAX[u];
          m_L[u] = L; m_N[u] = int'(cfg_samples); m_E[u] = int'(cfg_epochs);
          e_busy[u] = 1;
          if (m_L[u] == 0 || m_N[u] == 0 || m_E[u] == 0) m_mode[u] = 3;
          else begin
            m_op[u] = 0; h_s[u] = 0; h_l[u] = 0; h_e[u] = 0; m_mode[u] = 1;
          end
        end
        1: begin m_mode[u] = 2; e_fp[u] = 1; end
        2: begin
          dec(m_L[u], m_N[u], m_op[u], lay, smp, epn, isfp);
          if ((isfp && fpv[u]) || (!isfp && bpv[u])) begin
            m_op[u]++;
            if (!isfp && lay == 1 && m_op[u] == m_E[u] * m_N[u] * 2 * m_L[u]) begin
              e_sd[u] = 1; e_done[u] = 1; m_mode[u] = 4;
            end else begin
              dec(m_L[u], m_N[u], m_op[u], lay, smp, epn, nfp);
              h_l[u] = lay; h_s[u] = smp; h_e[u] = epn;
              if (!isfp && h_l[u] == 0) begin e_sd[u] = 1; m_mode[u] = 1; end
              else if (nfp) e_fp[u] = 1;
              else e_bp[u] = 1;
            end
          end
        end
        3: begin e_done[u] = 1; m_mode[u] = 0; e_busy[u] = 0; end
        default: begin m_mode[u] = 0; e_busy[u] = 0; end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) model_step(u);
    end
  end

  // ---------------- compare + event log ----------------
  int q_fpL0[$], q_fpS0[$], q_fpE0[$], q_bpL0[$], q_wr0[$], q_bpL1[$];
  int n_fp1 = 0, n_sd0 = 0, n_done0 = 0, done_cyc0 = 0;

  initial begin
    int lay, smp, epn;
    bit isfp, ewen;
    forever begin
      @(negedge clk); #1;
      if (cyc >= 1) begin
        for (int u = 0; u < 2; u++) begin
          ewen = 0;
          if (m_mode[u] == 2) begin
            dec(m_L[u], m_N[u], m_op[u], lay, smp, epn, isfp);
            ewen = isfp && fpv[u] && !rst && !abort;
          end
          chk("sample_addr", u, 32'(sa[u]), h_s[u]);
          chk("current_layer", u, 32'(cl[u]), h_l[u]);
          chk("epoch", u, 32'(ep[u]), h_e[u]);
          chk("fp_start", u, 32'(fps[u]), 32'(e_fp[u]));
          chk("bp_start", u, 32'(bps[u]), 32'(e_bp[u]));
          chk("sample_done", u, 32'(sd[u]), 32'(e_sd[u]));
          chk("busy", u, 32'(bz[u]), 32'(e_busy[u]));
          chk("done", u, 32'(dn[u]), 32'(e_done[u]));
          chk("stack_wr_en", u, 32'(wen[u]), 32'(ewen));
          if (ewen) chk("stack_wr_addr", u, 32'(wad[u]), (h_l[u] + 1) % 4);
        end
        if (fps[0] === 1'b1) begin
          q_fpL0.push_back(int'(cl[0])); q_fpS0.push_back(int'(sa[0])); q_fpE0.push_back(int'(ep[0]));
        end
        if (bps[0] === 1'b1) q_bpL0.push_back(int'(cl[0]));
        if (wen[0] === 1'b1) q_wr0.push_back(int'(wad[0]));
        if (sd[0] === 1'b1) n_sd0++;
        if (dn[0] === 1'b1) begin n_done0++; done_cyc0 = cyc; end
        if (fps[1] === 1'b1) n_fp1++;
        if (bps[1] === 1'b1) q_bpL1.push_back(int'(cl[1]));
      end
    end
  end

  // ---------------- valid responder ----------------
  int  rsp_delay = 3;   // 0 = random 1..4
  bit  rsp_spur = 0;

  initial begin
    int cnt [2];
    int pend [2];   // 0 none, 1 forward, 2 backward
    pend = '{0, 0};
    cnt  = '{0, 0};
    fpv[0] = 0; fpv[1] = 0; bpv[0] = 0; bpv[1] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        fpv[u] = 0; bpv[u] = 0;
        if (bz[u] !== 1'b1) pend[u] = 0;
        if (fps[u] === 1'b1) begin
          pend[u] = 1; cnt[u] = (rsp_delay > 0) ? rsp_delay : int'($urandom_range(1, 4));
        end else if (bps[u] === 1'b1) begin
          pend[u] = 2; cnt[u] = (rsp_delay > 0) ? rsp_delay : int'($urandom_range(1, 4));
        end else if (pend[u] != 0) begin
          cnt[u]--;
          if (cnt[u] == 0) begin
            if (pend[u] == 1) fpv[u] = 1; else bpv[u] = 1;
            pend[u] = 0;
          end
        end
        // wrong-kind or out-of-phase completions, all of which must be ignored
        if (rsp_spur && $urandom_range(0, 4) == 0) begin
          if (pend[u] == 1) bpv[u] = 1;
          else if (pend[u] == 2) fpv[u] = 1;
          else if (!fpv[u] && !bpv[u]) begin
            if ($urandom_range(0, 1) == 1) fpv[u] = 1; else bpv[u] = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int st_cyc = 0;
  int b_fpL, b_fpS, b_fpE, b_bpL, b_wr, b_bpL1, b_sd, b_done, b_fp1;

  task automatic snap();
    b_fpL = q_fpL0.size(); b_fpS = q_fpS0.size(); b_fpE = q_fpE0.size();
    b_bpL = q_bpL0.size(); b_wr = q_wr0.size(); b_bpL1 = q_bpL1.size();
    b_sd = n_sd0; b_done = n_done0; b_fp1 = n_fp1;
  endtask

  task automatic check_seq(input string name, input int q[$], input int base, input int e[$]);
    chk({name, "_len"}, 0, q.size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < q.size(); i++)
      chk(name, 0, q[base + i], e[i]);
  endtask

  task automatic run(input int L, input int N, input int E, input int abort_at,
                     input bit abort_on_bp, input int rst_at, input int budget);
    int n;
    bit ab_next, ab_fired;
    @(negedge clk);
    cfg_layers = 2'(L); cfg_samples = 10'(N); cfg_epochs = 8'(E);
    start = 1; st_cyc = cyc;
    @(negedge clk);
    start = 0;
    cfg_layers = 2'($urandom); cfg_samples = 10'($urandom); cfg_epochs = 8'($urandom);
    n = 0; ab_next = 0; ab_fired = 0;
    while ((bz[0] === 1'b1 || bz[1] === 1'b1) && n < budget) begin
      abort = ab_next; ab_next = 0;
      rst = (n == rst_at);
      start = 0;
      if (n == abort_at) abort = 1;
      if (abort_on_bp && !ab_fired && bps[0] === 1'b1) begin ab_next = 1; ab_fired = 1; end
      if (rsp_spur && !abort && !rst && bz[0] === 1'b1 && bz[1] === 1'b1 && $urandom_range(0, 19) == 0)
        start = 1;
      @(negedge clk);
      n++;
    end
    abort = 0; rst = 0; start = 0;
    chk("run_terminates", 0, 32'(n < budget), 1);
    @(negedge clk); #3;
  endtask

  initial begin
    int e[$];
    int L, N, E, ab, rs;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk); #3;

    // L=3, N=2, E=1, fixed 3-cycle response
    snap();
    run(3, 2, 1, -1, 0, -1, 2000);
    e = '{0, 1, 2, 0, 1, 2}; check_seq("A_fp_layer", q_fpL0, b_fpL, e);
    e = '{0, 0, 0, 1, 1, 1}; check_seq("A_fp_sample", q_fpS0, b_fpS, e);
    e = '{1, 2, 3, 1, 2, 3}; check_seq("A_wr_slot", q_wr0, b_wr, e);
    e = '{3, 2, 1, 3, 2, 1}; check_seq("A_bp_layer", q_bpL0, b_bpL, e);
    chk("A_sample_done_count", 0, n_sd0 - b_sd, 2);
    chk("A_done_count", 0, n_done0 - b_done, 1);
    chk("A_clamp_fp_count", 1, n_fp1 - b_fp1, 4);
    e = '{2, 1, 2, 1}; check_seq("A_clamp_bp_layer", q_bpL1, b_bpL1, e);

    // L=2, N=1, E=3
    snap();
    run(2, 1, 3, -1, 0, -1, 2000);
    e = '{0, 0, 1, 1, 2, 2}; check_seq("B_fp_epoch", q_fpE0, b_fpE, e);
    e = '{0, 0, 0, 0, 0, 0}; check_seq("B_fp_sample", q_fpS0, b_fpS, e);
    chk("B_sample_done_count", 0, n_sd0 - b_sd, 3);
    chk("B_done_count", 0, n_done0 - b_done, 1);

    // zero samples: done two cycles after start, no forward pass
    snap();
    run(3, 0, 2, -1, 0, -1, 100);
    chk("C_done_latency", 0, done_cyc0 - st_cyc, 2);
    chk("C_done_count", 0, n_done0 - b_done, 1);
    chk("C_fp_count", 0, q_fpL0.size() - b_fpL, 0);
    chk("C_fp_count", 1, n_fp1 - b_fp1, 0);

    // abort one cycle after the first bp_start, then a clean single-layer run
    snap();
    run(3, 2, 2, -1, 1, -1, 2000);
    chk("D_abort_no_done", 0, n_done0 - b_done, 0);
    chk("D_abort_bp_count", 0, q_bpL0.size() - b_bpL, 1);
    snap();
    run(1, 2, 1, -1, 0, -1, 2000);
    e = '{0, 0}; check_seq("D_fp_layer", q_fpL0, b_fpL, e);
    e = '{0, 1}; check_seq("D_fp_sample", q_fpS0, b_fpS, e);
    e = '{1, 1}; check_seq("D_bp_layer", q_bpL0, b_bpL, e);
    e = '{1, 1}; check_seq("D_wr_slot", q_wr0, b_wr, e);
    chk("D_done_count", 0, n_done0 - b_done, 1);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    cfg_layers = 2'd3; cfg_samples = 10'd1; cfg_epochs = 8'd1;
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("E_abort_beats_start", 0, 32'(bz[0]), 0);
    chk("E_abort_beats_start", 1, 32'(bz[1]), 0);
    @(negedge clk); #3;

    // randomized runs with random delays, spurious valids and stray starts
    rsp_delay = 0;
    rsp_spur = 1;
    for (int i = 0; i < 30; i++) begin
      L = int'($urandom_range(0, 3));
      N = int'($urandom_range(0, 3));
      E = int'($urandom_range(0, 2));
      ab = -1; rs = -1;
      if ($urandom_range(0, 5) == 0) ab = int'($urandom_range(0, 30));
      if ($urandom_range(0, 9) == 0) rs = int'($urandom_range(0, 30));
      run(L, N, E, ab, 0, rs, 3000);
    end

    repeat (3) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
